// File: rtl/qpimem_arbiter.sv
// qpimem_arbiter: grants the shared QPI PSRAM controller command interface to
// one of two requesters (port 0 = HUB75 framebuffer reader, port 1 = general
// purpose) for a whole burst. Ownership is held until the owner drops its
// request and the controller reports idle again.
module qpimem_arbiter #(
  parameter bit          ROUND_ROBIN = 1'b0,
  parameter int unsigned ADDR_W      = 24
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              p0_do_read,
  input  logic              p0_do_write,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [31:0]       p0_wdata,
  output logic [31:0]       p0_rdata,
  output logic              p0_next_word,
  output logic              p0_is_idle,

  input  logic              p1_do_read,
  input  logic              p1_do_write,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [31:0]       p1_wdata,
  output logic [31:0]       p1_rdata,
  output logic              p1_next_word,
  output logic              p1_is_idle,

  output logic              m_do_read,
  output logic              m_do_write,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata,
  input  logic              m_next_word,
  input  logic              m_is_idle
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BURST,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_owner;
  logic   w_owner_nxt;
  logic   r_prio;
  logic   w_prio_nxt;

  logic   w_p0_req;
  logic   w_p1_req;
  logic   w_own_req;

  assign w_p0_req  = p0_do_read | p0_do_write;
  assign w_p1_req  = p1_do_read | p1_do_write;
  assign w_own_req = r_owner ? w_p1_req : w_p0_req;

  // Read data is shared; only the owner sees next_word, so it knows which words are its own.
  assign p0_rdata = m_rdata;
  assign p1_rdata = m_rdata;

  // State, owner and priority registers; reset may land mid-burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_owner <= 1'b0;
      r_prio  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_prio  <= w_prio_nxt;
    end
  end

  // Next-state logic: grant in IDLE, release on request drop, wait for controller idle in DRAIN.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_prio_nxt  = r_prio;
    case (r_state)
      S_IDLE: begin
        if (m_is_idle && (w_p0_req || w_p1_req)) begin
          w_state_nxt = S_BURST;
          w_owner_nxt = (w_p0_req && w_p1_req) ? r_prio : w_p1_req;
        end
      end
      S_BURST: begin
        if (!w_own_req) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (m_is_idle) begin
          w_state_nxt = S_IDLE;
          // With fixed priority prio never leaves 0.
          if (ROUND_ROBIN) begin
            w_prio_nxt = ~r_owner;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output mux: the owner's command lines pass straight through during BURST;
  // next_word keeps following the owner through DRAIN so a late word is not lost.
  always_comb begin
    m_do_read    = 1'b0;
    m_do_write   = 1'b0;
    m_addr       = '0;
    m_wdata      = '0;
    p0_next_word = 1'b0;
    p1_next_word = 1'b0;
    p0_is_idle   = m_is_idle;
    p1_is_idle   = m_is_idle;
    case (r_state)
      S_BURST: begin
        if (r_owner) begin
          m_do_read    = p1_do_read;
          m_do_write   = p1_do_write;
          m_addr       = p1_addr;
          m_wdata      = p1_wdata;
          p1_next_word = m_next_word;
          p0_is_idle   = 1'b1;
        end else begin
          m_do_read    = p0_do_read;
          m_do_write   = p0_do_write;
          m_addr       = p0_addr;
          m_wdata      = p0_wdata;
          p0_next_word = m_next_word;
          p1_is_idle   = 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_owner) begin
          p1_next_word = m_next_word;
          p0_is_idle   = 1'b1;
        end else begin
          p0_next_word = m_next_word;
          p1_is_idle   = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_qpimem_arbiter.sv
// tb_qpimem_arbiter: drives a fixed-priority and a round-robin arbiter with the
// same requester commands. Reactive requester/controller models run the bursts;
// expected grants are queued per instance and checked by a separate monitor.
`timescale 1ns/1ps
module tb_qpimem_arbiter;
  localparam int AW = 24;

  typedef struct {
    int            port;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          rd;
    logic          wr;
    int            n;
    int            lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  // Index [d][p]: d = instance (0 fixed priority, 1 round robin), p = port.
  logic          rq_rd    [2][2];
  logic          rq_wr    [2][2];
  logic [AW-1:0] rq_addr  [2][2];
  logic [31:0]   rq_wdata [2][2];
  logic [31:0]   p_rdata  [2][2];
  logic          p_nw     [2][2];
  logic          p_idle   [2][2];
  logic          m_rd     [2];
  logic          m_wr     [2];
  logic [AW-1:0] m_addr   [2];
  logic [31:0]   m_wdata  [2];
  logic [31:0]   m_rdata  [2];
  logic          m_nw     [2];
  logic          m_idle   [2];

  // Per-port commands from the main sequence, applied to both instances.
  logic          c_rd [2];
  logic          c_wr [2];
  logic [AW-1:0] c_addr [2];
  logic [31:0]   c_wdata [2];
  int            c_n [2];
  int            c_seq [2];
  int            kill_seq  = 0;
  int            abort_seq = 0;
  bit            late_word = 1'b0;

  int   last_issue [2];
  int   last_rise  [2];
  bit   in_b       [2];
  exp_t sbq0[$];
  exp_t sbq1[$];
  int   vectors = 0;
  int   fails   = 0;

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  qpimem_arbiter #(.ROUND_ROBIN(1'b0), .ADDR_W(AW)) u_fix (
    .clk(clk), .rst(rst),
    .p0_do_read(rq_rd[0][0]), .p0_do_write(rq_wr[0][0]), .p0_addr(rq_addr[0][0]),
    .p0_wdata(rq_wdata[0][0]), .p0_rdata(p_rdata[0][0]), .p0_next_word(p_nw[0][0]),
    .p0_is_idle(p_idle[0][0]),
    .p1_do_read(rq_rd[0][1]), .p1_do_write(rq_wr[0][1]), .p1_addr(rq_addr[0][1]),
    .p1_wdata(rq_wdata[0][1]), .p1_rdata(p_rdata[0][1]), .p1_next_word(p_nw[0][1]),
    .p1_is_idle(p_idle[0][1]),
    .m_do_read(m_rd[0]), .m_do_write(m_wr[0]), .m_addr(m_addr[0]), .m_wdata(m_wdata[0]),
    .m_rdata(m_rdata[0]), .m_next_word(m_nw[0]), .m_is_idle(m_idle[0])
  );

  qpimem_arbiter #(.ROUND_ROBIN(1'b1), .ADDR_W(AW)) u_rr (
    .clk(clk), .rst(rst),
    .p0_do_read(rq_rd[1][0]), .p0_do_write(rq_wr[1][0]), .p0_addr(rq_addr[1][0]),
    .p0_wdata(rq_wdata[1][0]), .p0_rdata(p_rdata[1][0]), .p0_next_word(p_nw[1][0]),
    .p0_is_idle(p_idle[1][0]),
    .p1_do_read(rq_rd[1][1]), .p1_do_write(rq_wr[1][1]), .p1_addr(rq_addr[1][1]),
    .p1_wdata(rq_wdata[1][1]), .p1_rdata(p_rdata[1][1]), .p1_next_word(p_nw[1][1]),
    .p1_is_idle(p_idle[1][1]),
    .m_do_read(m_rd[1]), .m_do_write(m_wr[1]), .m_addr(m_addr[1]), .m_wdata(m_wdata[1]),
    .m_rdata(m_rdata[1]), .m_next_word(m_nw[1]), .m_is_idle(m_idle[1])
  );

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] want);
    vectors++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
    end
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Requesters hold their lines until they have counted n words; the controller
  // streams one word per requested cycle and stays busy 2 cycles after release.
  initial begin
    int  seen_seq [2];
    int  seen_kill;
    int  rem [2][2];
    bit  active [2][2];
    int  ccnt [2];
    int  since [2];
    bit  kill;
    bit  newc [2];
    seen_kill = 0;
    for (int d = 0; d < 2; d++) begin
      seen_seq[d] = 0; ccnt[d] = 0; since[d] = 100; last_issue[d] = 0;
      m_nw[d] = 1'b0; m_idle[d] = 1'b1; m_rdata[d] = '0;
      for (int p = 0; p < 2; p++) begin
        rq_rd[d][p] = 1'b0; rq_wr[d][p] = 1'b0; rq_addr[d][p] = '0; rq_wdata[d][p] = '0;
        rem[d][p] = 0; active[d][p] = 1'b0;
      end
    end
    forever begin
      @(posedge clk);
      #1;
      kill = (kill_seq != seen_kill);
      seen_kill = kill_seq;
      for (int p = 0; p < 2; p++) begin
        newc[p] = (c_seq[p] != seen_seq[p]);
        seen_seq[p] = c_seq[p];
      end
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < 2; p++) begin
          if (kill) begin
            active[d][p] = 1'b0; rq_rd[d][p] = 1'b0; rq_wr[d][p] = 1'b0;
          end else if (newc[p]) begin
            active[d][p] = 1'b1; rq_rd[d][p] = c_rd[p]; rq_wr[d][p] = c_wr[p];
            rq_addr[d][p] = c_addr[p]; rq_wdata[d][p] = c_wdata[p];
            rem[d][p] = c_n[p]; last_issue[d] = cyc;
          end else if (active[d][p] && rem[d][p] <= 0) begin
            active[d][p] = 1'b0; rq_rd[d][p] = 1'b0; rq_wr[d][p] = 1'b0;
          end
        end
      end
      #1;
      for (int d = 0; d < 2; d++) begin
        m_rdata[d] = 32'(cyc) * 32'h9E3779B1 + 32'(d);
        if (m_rd[d] || m_wr[d]) begin
          ccnt[d] = 2; since[d] = 0; m_nw[d] = 1'b1; m_idle[d] = 1'b0;
        end else begin
          since[d]++;
          m_nw[d] = late_word && (since[d] == 2);
          if (ccnt[d] > 0) begin
            ccnt[d]--; m_idle[d] = 1'b0;
          end else begin
            m_idle[d] = 1'b1;
          end
        end
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < 2; p++)
          if (active[d][p] && p_nw[d][p]) rem[d][p]--;
    end
  end

  // Monitor: on each grant pops the expected burst; checks command lines, grant
  // latency, word routing, is_idle and rdata broadcast until the controller is idle again.
  initial begin
    bit   prev_do [2];
    bit   prev_idle [2];
    bit   fell [2];
    bit   hold_bad [2];
    bit   idle_bad [2];
    bit   path_bad [2];
    int   cnt [2][2];
    exp_t cur [2];
    exp_t e;
    bit   got;
    bit   do_now;
    int   seen_abort;
    int   o;
    seen_abort = 0;
    for (int d = 0; d < 2; d++) begin
      prev_do[d] = 1'b0; prev_idle[d] = 1'b1; in_b[d] = 1'b0; last_rise[d] = 0;
    end
    forever begin
      @(negedge clk);
      if (abort_seq != seen_abort) begin
        seen_abort = abort_seq;
        in_b[0] = 1'b0; in_b[1] = 1'b0;
      end
      for (int d = 0; d < 2; d++) begin
        do_now = m_rd[d] | m_wr[d];
        if (m_idle[d] && !prev_idle[d]) last_rise[d] = cyc;
        if (!in_b[d] && do_now && !prev_do[d]) begin
          got = 1'b0;
          if (d == 0 && sbq0.size() > 0) begin e = sbq0.pop_front(); got = 1'b1; end
          if (d == 1 && sbq1.size() > 0) begin e = sbq1.pop_front(); got = 1'b1; end
          check("grant_expected", got, 1'b1);
          if (got) begin
            check("grant_cmd", {m_rd[d], m_wr[d], m_addr[d], m_wdata[d]},
                  {e.rd, e.wr, e.addr, e.wdata});
            check("grant_latency", 64'(cyc - imax(last_issue[d], last_rise[d])), 64'(e.lat));
            cur[d] = e; in_b[d] = 1'b1; fell[d] = 1'b0;
            hold_bad[d] = 1'b0; idle_bad[d] = 1'b0; path_bad[d] = 1'b0;
            cnt[d][0] = 0; cnt[d][1] = 0;
          end
        end
        if (in_b[d]) begin
          o = cur[d].port;
          for (int p = 0; p < 2; p++) if (p_nw[d][p]) cnt[d][p]++;
          if (do_now && (fell[d] || m_addr[d] !== cur[d].addr || m_wdata[d] !== cur[d].wdata ||
              m_rd[d] !== cur[d].rd || m_wr[d] !== cur[d].wr)) hold_bad[d] = 1'b1;
          if (!do_now) fell[d] = 1'b1;
          if (p_idle[d][o] !== m_idle[d] || p_idle[d][1-o] !== 1'b1) idle_bad[d] = 1'b1;
          if (p_rdata[d][0] !== m_rdata[d] || p_rdata[d][1] !== m_rdata[d]) path_bad[d] = 1'b1;
          if (fell[d] && m_idle[d]) begin
            check("owner_words", 64'(cnt[d][o]), 64'(cur[d].n));
            check("other_words", 64'(cnt[d][1-o]), 64'd0);
            check("burst_hold_idle_rdata", {hold_bad[d], idle_bad[d], path_bad[d]}, 64'd0);
            in_b[d] = 1'b0;
          end
        end
        prev_do[d] = do_now;
        prev_idle[d] = m_idle[d];
      end
    end
  end

  task automatic push(input int d, input int p, input logic [AW-1:0] a, input logic [31:0] w,
                      input logic rd, input logic wr, input int n, input int lat);
    exp_t e;
    e.port = p; e.addr = a; e.wdata = w; e.rd = rd; e.wr = wr; e.n = n; e.lat = lat;
    if (d == 0) sbq0.push_back(e); else sbq1.push_back(e);
  endtask

  task automatic push_both(input int p, input logic [AW-1:0] a, input logic [31:0] w,
                           input logic rd, input logic wr, input int n, input int lat);
    push(0, p, a, w, rd, wr, n, lat);
    push(1, p, a, w, rd, wr, n, lat);
  endtask

  task automatic issue(input int p, input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [31:0] w, input int n);
    c_rd[p] = rd; c_wr[p] = wr; c_addr[p] = a; c_wdata[p] = w; c_n[p] = n;
    c_seq[p] = c_seq[p] + 1;
  endtask

  function automatic bit is_quiet();
    bit q;
    q = (sbq0.size() == 0) && (sbq1.size() == 0);
    for (int d = 0; d < 2; d++) begin
      q = q && !in_b[d] && !m_rd[d] && !m_wr[d] && m_idle[d];
      for (int p = 0; p < 2; p++) q = q && !rq_rd[d][p] && !rq_wr[d][p];
    end
    return q;
  endfunction

  task automatic wait_quiet();
    bit done;
    done = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk);
      done = is_quiet();
    end
    check("quiet_timeout", {63'd0, done}, 64'd1);
    #1;
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      c_rd[p] = 1'b0; c_wr[p] = 1'b0; c_addr[p] = '0; c_wdata[p] = '0; c_n[p] = 0; c_seq[p] = 0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("reset_cmd", {m_rd[d], m_wr[d], m_addr[d], m_wdata[d]}, 64'd0);
      check("reset_nw_idle", {p_nw[d][0], p_nw[d][1], p_idle[d][0], p_idle[d][1]}, 64'b0011);
    end
    rst = 1'b0;
    @(negedge clk);
    #1;

    // Port 0 read of 4 words.
    push_both(0, 24'h001000, 32'h0, 1'b1, 1'b0, 4, 1);
    issue(0, 1'b1, 1'b0, 24'h001000, 32'h0, 4);
    wait_quiet();

    // Port 1 write while port 0 is idle.
    push_both(1, 24'h002000, 32'hDEADBEEF, 1'b0, 1'b1, 3, 1);
    issue(1, 1'b0, 1'b1, 24'h002000, 32'hDEADBEEF, 3);
    wait_quiet();

    // Simultaneous requests, three rounds: port 0 first, port 1 after the drain.
    for (int r = 0; r < 3; r++) begin
      push_both(0, 24'h000100 + 24'(r), 32'h11110000 + 32'(r), 1'b1, 1'b0, 2, 1);
      push_both(1, 24'h000200 + 24'(r), 32'h22220000 + 32'(r), 1'b0, 1'b1, 2, 2);
      issue(0, 1'b1, 1'b0, 24'h000100 + 24'(r), 32'h11110000 + 32'(r), 2);
      issue(1, 1'b0, 1'b1, 24'h000200 + 24'(r), 32'h22220000 + 32'(r), 2);
      wait_quiet();
    end

    // Lone port 0 burst, then a tie: round robin now favours port 1.
    push_both(0, 24'h003000, 32'h0, 1'b1, 1'b0, 1, 1);
    issue(0, 1'b1, 1'b0, 24'h003000, 32'h0, 1);
    wait_quiet();
    push(0, 0, 24'h003100, 32'h31, 1'b1, 1'b0, 2, 1);
    push(0, 1, 24'h003200, 32'h32, 1'b1, 1'b0, 2, 2);
    push(1, 1, 24'h003200, 32'h32, 1'b1, 1'b0, 2, 1);
    push(1, 0, 24'h003100, 32'h31, 1'b1, 1'b0, 2, 2);
    issue(0, 1'b1, 1'b0, 24'h003100, 32'h31, 2);
    issue(1, 1'b1, 1'b0, 24'h003200, 32'h32, 2);
    wait_quiet();

    // Port 0 requests during a port 1 burst and waits for the next IDLE.
    push_both(1, 24'h004000, 32'hCAFEF00D, 1'b0, 1'b1, 6, 1);
    push_both(0, 24'h005000, 32'h55, 1'b1, 1'b0, 2, 2);
    issue(1, 1'b0, 1'b1, 24'h004000, 32'hCAFEF00D, 6);
    repeat (2) @(negedge clk);
    #1;
    issue(0, 1'b1, 1'b0, 24'h005000, 32'h55, 2);
    wait_quiet();

    // A controller word arriving in DRAIN still reaches the owner.
    late_word = 1'b1;
    push_both(0, 24'h006000, 32'h0, 1'b1, 1'b0, 4, 1);
    issue(0, 1'b1, 1'b0, 24'h006000, 32'h0, 3);
    wait_quiet();
    late_word = 1'b0;

    // Asynchronous reset between clock edges in the middle of a burst.
    push_both(0, 24'h007000, 32'h0, 1'b1, 1'b0, 20, 1);
    issue(0, 1'b1, 1'b0, 24'h007000, 32'h0, 20);
    repeat (3) @(posedge clk);
    #3;
    abort_seq = abort_seq + 1;
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("midreset_cmd", {m_rd[d], m_wr[d], m_addr[d], m_wdata[d]}, 64'd0);
      check("midreset_nw", {m_nw[d], p_nw[d][0], p_nw[d][1]}, 64'b100);
    end
    #1;
    rst = 1'b0;
    kill_seq = kill_seq + 1;
    wait_quiet();

    push_both(1, 24'h008000, 32'h8888, 1'b1, 1'b0, 2, 1);
    issue(1, 1'b1, 1'b0, 24'h008000, 32'h8888, 2);
    wait_quiet();

    // Read and write together are forwarded unmodified.
    push_both(0, 24'h009000, 32'h99, 1'b1, 1'b1, 2, 1);
    issue(0, 1'b1, 1'b1, 24'h009000, 32'h99, 2);
    wait_quiet();

    check("scoreboard_drained", 64'(sbq0.size() + sbq1.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
